// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default ack window.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } arb_state_e;

    localparam int ACK_TO_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          hit
);

    always_comb begin
        logic [IW-1:0] j;
        j    = '0;
        pick = last;
        hit  = 1'b0;
        // Scan from the farthest candidate back so the nearest one after 'last' wins.
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N);
            if (req[j]) begin
                pick = j;
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N_REQ byte sources onto one UART transmitter with lockable bursts and an ack timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ACK_TO = ACK_TO_DEF,
    parameter int GW     = $clog2(N_REQ),
    parameter int CW     = $clog2(ACK_TO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_lock,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 err_timeout
);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);

    arb_state_e                state, state_nxt;
    logic [CW-1:0]             cnt;
    logic [GW-1:0]             pick;
    logic                      hit;
    logic [N_REQ-1:0][7:0]     req_bytes;

    assign req_bytes = req_data;

    rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
        .req  (req_valid),
        .last (grant_id),
        .pick (pick),
        .hit  (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= GW'(N_REQ - 1);
            tx_data  <= 8'h00;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_GRANT)
                grant_id <= pick;
            // tx_data only moves here, so it holds across the whole frame.
            if (state == ST_GRANT)
                tx_data <= req_bytes[grant_id];
            if (state == ST_START)
                cnt <= '0;
            else if (state == ST_WAIT_ACK && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit && !tx_busy)
                    state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                req_ready[grant_id] = 1'b1;
                state_nxt           = ST_START;
            end
            ST_START: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (cnt == ACK_LAST) begin
                    err_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                // A locked owner with another byte ready skips arbitration.
                if (!tx_busy)
                    state_nxt = (req_lock[grant_id] && req_valid[grant_id]) ? ST_GRANT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against an event-scheduling model, plus directed scenarios.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_lock = '0, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic           tx_start, tx_busy = 1'b0, err_timeout;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    uart_tx_arb #(.N_REQ(N), .ACK_TO(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;

    // requester sources
    logic [7:0] q [N][$];
    bit         lkq [N][$];
    int         gap [N];
    bit         pop_pend [N];
    bit         rst_q;

    // model: scheduled cycle numbers of every expected event
    int m_gid, m_txd, upd_gid_at, upd_gid_val, upd_txd_at, upd_txd_val;
    int exp_ready_at, exp_w, exp_start_at, exp_err_at;
    int busy_lo, busy_hi, fall_at, spur_until, dec_from;
    bit txn;

    bit rnd, force_to;
    int d_fix, l_fix;

    int lg_rdy_cyc[$], lg_rdy_id[$], lg_st_cyc[$], lg_st_dat[$], lg_st_gid[$], lg_err_cyc[$], lg_rx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] at(input int qq[$], input int i);
        return (i < qq.size()) ? qq[i] : 32'hdead;
    endfunction

    function automatic int rr(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_gid = N - 1; m_txd = 0; txn = 0;
        upd_gid_at = -1; upd_txd_at = -1; upd_gid_val = 0; upd_txd_val = 0;
        exp_ready_at = -1; exp_w = 0; exp_start_at = -1; exp_err_at = -1;
        busy_lo = 1; busy_hi = 0; fall_at = -1; spur_until = 0; dec_from = 0;
        for (int i = 0; i < N; i++) begin
            q[i].delete(); lkq[i].delete(); gap[i] = 0; pop_pend[i] = 0;
        end
    endtask

    task automatic clear_logs();
        lg_rdy_cyc.delete(); lg_rdy_id.delete(); lg_st_cyc.delete(); lg_st_dat.delete();
        lg_st_gid.delete(); lg_err_cyc.delete(); lg_rx.delete();
    endtask

    task automatic push(input int i, input logic [7:0] b, input bit l);
        q[i].push_back(b);
        lkq[i].push_back(l);
    endtask

    // Grant to w decided in this cycle; also plans how the transmitter will respond.
    task automatic sched(input int w);
        int s, d, l;
        bit to;
        exp_w = w; exp_ready_at = cyc + 1;
        upd_gid_at = cyc + 1; upd_gid_val = w;
        upd_txd_at = cyc + 2; upd_txd_val = q[w][0];
        exp_start_at = cyc + 2; s = cyc + 2;
        if (rnd) begin
            to = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
            l  = $urandom_range(1, 4);
        end else begin
            to = force_to; force_to = 0; d = d_fix; l = l_fix;
        end
        if (to) begin
            exp_err_at = s + TO; busy_lo = 1; busy_hi = 0; fall_at = -1;
        end else begin
            exp_err_at = -1; busy_lo = s + 1 + d; busy_hi = s + d + l; fall_at = busy_hi + 1;
        end
        txn = 1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pop_pend[i]) begin
                if (q[i].size() > 0) begin void'(q[i].pop_front()); void'(lkq[i].pop_front()); end
                pop_pend[i] = 0;
                if (rnd) gap[i] = $urandom_range(0, 3);
            end else if (gap[i] > 0) gap[i]--;
            if (rnd && q[i].size() < 4 && $urandom_range(0, 9) == 0)
                push(i, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
        end
        if (rnd && !txn && cyc >= spur_until && $urandom_range(0, 39) == 0)
            spur_until = cyc + $urandom_range(1, 5);
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = (q[i].size() > 0) && (gap[i] == 0);
            req_data[8*i+:8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
            req_lock[i]      = (q[i].size() > 0) ? lkq[i][0] : 1'b0;
        end
        tx_busy = (cyc >= busy_lo && cyc <= busy_hi) || (cyc < spur_until);
        rst = rst_q;
    endtask

    task automatic check_update();
        if (cyc == upd_gid_at) m_gid = upd_gid_val;
        if (cyc == upd_txd_at) m_txd = upd_txd_val;
        chk("req_ready",   req_ready,   (cyc == exp_ready_at) ? (1 << exp_w) : 0);
        chk("tx_start",    tx_start,    cyc == exp_start_at);
        chk("err_timeout", err_timeout, cyc == exp_err_at);
        chk("grant_id",    grant_id,    m_gid);
        chk("tx_data",     tx_data,     m_txd);
        for (int i = 0; i < N; i++)
            if (req_ready[i] === 1'b1) begin
                lg_rdy_cyc.push_back(cyc); lg_rdy_id.push_back(i); pop_pend[i] = 1;
            end
        if (tx_start === 1'b1) begin
            lg_st_cyc.push_back(cyc); lg_st_dat.push_back(tx_data); lg_st_gid.push_back(grant_id);
        end
        if (err_timeout === 1'b1) lg_err_cyc.push_back(cyc);
        if (cyc == busy_hi) lg_rx.push_back(tx_data);
        if (!rst) begin
            if (txn && cyc == fall_at) begin
                if (req_valid[exp_w] && req_lock[exp_w]) sched(exp_w);
                else begin txn = 0; dec_from = cyc + 1; end
            end else if (txn && cyc == exp_err_at) begin
                txn = 0; dec_from = cyc + 1;
            end else if (!txn && cyc >= dec_from && req_valid != '0 && !tx_busy) begin
                sched(rr(req_valid, m_gid));
            end
        end
    endtask

    task automatic step();
        @(posedge clk); cyc++; #1; drive();
        @(negedge clk); check_update();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int t0, b;
        rst_q = 1; rnd = 0; force_to = 0; d_fix = 1; l_fix = 3;
        model_reset();
        run(3);
        chk("reset grant_id", grant_id, 2'd3);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset req_ready", req_ready, 4'h0);
        rst_q = 0;
        run(3);

        // all four requesters at once
        clear_logs();
        push(0, 8'h11, 0); push(1, 8'h22, 0); push(2, 8'h33, 0); push(3, 8'h44, 0);
        run(60);
        chk("all4 count", lg_st_dat.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("all4 byte", at(lg_st_dat, i), 32'h11 * (i + 1));
            chk("all4 gid", at(lg_st_gid, i), i);
        end

        // single request latency and loopback
        clear_logs();
        t0 = cyc + 1;
        push(0, 8'h5A, 0);
        run(20);
        chk("single ready lat", at(lg_rdy_cyc, 0) - t0, 1);
        chk("single start lat", at(lg_st_cyc, 0) - t0, 2);
        chk("single tx_data", at(lg_st_dat, 0), 8'h5A);
        chk("single rx byte", at(lg_rx, 0), 8'h5A);

        // locked burst from 2 while 1 waits
        clear_logs();
        push(2, 8'hA1, 1); push(2, 8'hA2, 1); push(2, 8'hA3, 1);
        step();
        push(1, 8'hB1, 0);
        run(60);
        chk("lock order0", at(lg_st_dat, 0), 8'hA1);
        chk("lock order1", at(lg_st_dat, 1), 8'hA2);
        chk("lock order2", at(lg_st_dat, 2), 8'hA3);
        chk("lock order3", at(lg_st_dat, 3), 8'hB1);
        chk("lock gid2", at(lg_st_gid, 2), 2);
        chk("lock gid3", at(lg_st_gid, 3), 1);

        // ack timeout, then the next request is still served
        clear_logs();
        force_to = 1;
        push(3, 8'hC3, 0); push(0, 8'hD0, 0);
        run(60);
        chk("timeout count", lg_err_cyc.size(), 1);
        chk("timeout delay", at(lg_err_cyc, 0) - at(lg_st_cyc, 0), TO);
        chk("timeout next byte", at(lg_st_dat, 1), 8'hD0);

        // transmitter busy when the request arrives
        clear_logs();
        spur_until = cyc + 9;
        b = spur_until;
        push(0, 8'h66, 0);
        run(30);
        chk("busy ready delay", at(lg_rdy_cyc, 0) - b, 1);
        chk("busy byte", at(lg_st_dat, 0), 8'h66);

        // reset during WAIT_DONE
        clear_logs();
        l_fix = 20;
        push(1, 8'hE1, 0);
        for (int k = 0; k < 40 && !(txn && cyc == busy_lo + 2); k++) step();
        chk("pre-reset grant_id", grant_id, 2'd1);
        #2 rst = 1'b1; rst_q = 1;
        #1;
        chk("async rst req_ready", req_ready, 4'h0);
        chk("async rst tx_start", tx_start, 1'b0);
        chk("async rst tx_data", tx_data, 8'h00);
        chk("async rst grant_id", grant_id, 2'd3);
        chk("async rst err", err_timeout, 1'b0);
        model_reset();
        l_fix = 3;
        run(3);
        rst_q = 0;
        clear_logs();
        run(15);
        chk("post-reset no start", lg_st_cyc.size(), 0);
        push(2, 8'h77, 0);
        run(20);
        chk("post-reset byte", at(lg_st_dat, 0), 8'h77);
        chk("post-reset gid", at(lg_st_gid, 0), 2);

        // randomized traffic, then drain
        rnd = 1;
        run(4000);
        rnd = 0;
        run(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
